// File: rtl/execute_pipe_skid_if.sv
// EX->MEM bundle interface: flush, both handshakes, the carried fields and the occupancy debug view.
// The slave modport is the stage's view; the master modport is the EX/MEM/hazard environment's view.
interface execute_pipe_skid_if #(
  parameter int XLEN     = 32,
  parameter int MEMREG_W = 2
) ();
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic                load_in;
  logic                store_in;
  logic [MEMREG_W-1:0] mem_reg_in;
  logic [XLEN-1:0]     opb_datain;
  logic [XLEN-1:0]     alu_res;
  logic [XLEN-1:0]     next_sel_addr;
  logic [XLEN-1:0]     pre_address_in;
  logic [XLEN-1:0]     instruction_in;
  logic                out_valid;
  logic                out_ready;
  logic                load_out;
  logic                store_out;
  logic [MEMREG_W-1:0] mem_reg_out;
  logic [XLEN-1:0]     opb_dataout;
  logic [XLEN-1:0]     alu_res_out;
  logic [XLEN-1:0]     next_sel_address;
  logic [XLEN-1:0]     pre_address_out;
  logic [XLEN-1:0]     instruction_out;
  logic [1:0]          occupancy;

  modport slave (
    input  flush, in_valid, load_in, store_in, mem_reg_in, opb_datain, alu_res,
           next_sel_addr, pre_address_in, instruction_in, out_ready,
    output in_ready, out_valid, load_out, store_out, mem_reg_out, opb_dataout,
           alu_res_out, next_sel_address, pre_address_out, instruction_out, occupancy
  );

  modport master (
    output flush, in_valid, load_in, store_in, mem_reg_in, opb_datain, alu_res,
           next_sel_addr, pre_address_in, instruction_in, out_ready,
    input  in_ready, out_valid, load_out, store_out, mem_reg_out, opb_dataout,
           alu_res_out, next_sel_address, pre_address_out, instruction_out, occupancy
  );
endinterface

// File: rtl/execute_pipe_skid.sv
// EX->MEM stage register with a 2-entry skid buffer (main drives outputs, skid catches one extra bundle)
// so in_ready can be a flop. Handshake: a bundle moves on a side only in a cycle where valid & ready are both 1.
module execute_pipe_skid #(
  parameter int          XLEN     = 32,
  parameter int          MEMREG_W = 2,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input logic                 clk,
  input logic                 rst,
  execute_pipe_skid_if.slave  bus
);
  typedef struct packed {
    logic                load;
    logic                store;
    logic [MEMREG_W-1:0] mem_reg;
    logic [XLEN-1:0]     opb;
    logic [XLEN-1:0]     alu;
    logic [XLEN-1:0]     next_pc;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     insn;
  } bundle_t;

  bundle_t r_main, r_skid, w_main_nxt, w_skid_nxt, w_in;
  logic    r_main_valid, r_skid_valid, r_in_ready;
  logic    w_main_valid_nxt, w_skid_valid_nxt;
  logic    w_accept, w_deliver;

  assign w_in = '{load: bus.load_in, store: bus.store_in, mem_reg: bus.mem_reg_in,
                  opb: bus.opb_datain, alu: bus.alu_res, next_pc: bus.next_sel_addr,
                  pc: bus.pre_address_in, insn: bus.instruction_in};

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_deliver = r_main_valid & bus.out_ready;

  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (r_skid_valid) begin
      // in_ready is 0 here, so only a delivery can change state
      if (w_deliver) begin
        w_main_nxt       = r_skid;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (r_main_valid) begin
      if (w_accept && w_deliver) begin
        w_main_nxt = w_in;
      end else if (w_accept) begin
        w_skid_nxt       = w_in;
        w_skid_valid_nxt = 1'b1;
      end else if (w_deliver) begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_main_nxt       = w_in;
      w_main_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (bus.flush) begin
      // Data is left as-is; only the valid bits matter after a kill
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.out_valid        = r_main_valid;
  assign bus.load_out         = r_main.load & r_main_valid;
  assign bus.store_out        = r_main.store & r_main_valid;
  assign bus.mem_reg_out      = r_main.mem_reg;
  assign bus.opb_dataout      = r_main.opb;
  assign bus.alu_res_out      = r_main.alu;
  assign bus.next_sel_address = r_main.next_pc;
  assign bus.pre_address_out  = r_main.pc;
  assign bus.instruction_out  = r_main_valid ? r_main.insn : XLEN'(NOP_INSN);
  assign bus.occupancy        = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
endmodule

// File: tb/tb_execute_pipe_skid.sv
// Directed bench for execute_pipe_skid: reset, streaming, stall/drain, flush, store gating, reset mid-stall.
module tb_execute_pipe_skid;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  execute_pipe_skid_if #(.XLEN(32), .MEMREG_W(2)) bus ();

  execute_pipe_skid dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] mr,
                       input logic [31:0] opb, input logic [31:0] alu, input logic [31:0] npc,
                       input logic [31:0] pc, input logic [31:0] insn);
    bus.in_valid       = v;
    bus.load_in        = ld;
    bus.store_in       = st;
    bus.mem_reg_in     = mr;
    bus.opb_datain     = opb;
    bus.alu_res        = alu;
    bus.next_sel_addr  = npc;
    bus.pre_address_in = pc;
    bus.instruction_in = insn;
  endtask

  task automatic send_alu(input logic [31:0] alu);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 32'h0, alu, 32'h0, 32'h0, 32'h00000033);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'd3, 32'hdead, 32'hbeef, 32'h44, 32'h40, 32'h00112233);

    // 1. reset with in_valid held high
    tick();
    tick();
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_insn", bus.instruction_out, 32'h13);
    check_eq("rst_load", bus.load_out, 0);
    check_eq("rst_occ", bus.occupancy, 0);
    check_eq("rst_alu", bus.alu_res_out, 0);
    rst = 1'b0;
    idle();
    tick();
    check_eq("post_rst_idle_valid", bus.out_valid, 0);

    // 2. streaming with out_ready=1
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      send_alu(32'(i));
      tick();
      check_eq($sformatf("stream_alu_%0d", i), bus.alu_res_out, 64'(i));
      check_eq($sformatf("stream_valid_%0d", i), bus.out_valid, 1);
      check_eq($sformatf("stream_occ_%0d", i), bus.occupancy, 1);
      check_eq($sformatf("stream_rdy_%0d", i), bus.in_ready, 1);
    end
    idle();
    tick();
    check_eq("stream_drained_valid", bus.out_valid, 0);
    check_eq("stream_drained_occ", bus.occupancy, 0);

    // 3. stall, fill both entries, then drain in order
    bus.out_ready = 1'b0;
    send_alu(32'hA5);
    exp_q.push_back(32'hA5);
    tick();
    check_eq("stall_a_alu", bus.alu_res_out, 32'hA5);
    check_eq("stall_a_rdy", bus.in_ready, 1);
    send_alu(32'hB6);
    exp_q.push_back(32'hB6);
    tick();
    check_eq("stall_b_rdy", bus.in_ready, 0);
    check_eq("stall_b_occ", bus.occupancy, 2);
    check_eq("stall_b_hold", bus.alu_res_out, 32'hA5);
    idle();
    tick();
    check_eq("stall_hold2", bus.alu_res_out, 32'hA5);
    check_eq("stall_hold2_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check_eq("drain_valid", bus.out_valid, 1);
      check_eq("drain_alu", bus.alu_res_out, exp_q.pop_front());
      tick();
    end
    check_eq("drain_done_valid", bus.out_valid, 0);
    check_eq("drain_done_rdy", bus.in_ready, 1);

    // 4a. flush with two stored entries and C presented
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h11, 32'hD1, 32'h0, 32'h0, 32'h00a12023);
    tick();
    drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h22, 32'hD2, 32'h0, 32'h0, 32'h00a12023);
    tick();
    check_eq("pre_flush_occ", bus.occupancy, 2);
    check_eq("pre_flush_store", bus.store_out, 1);
    send_alu(32'hC0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    check_eq("flush_valid", bus.out_valid, 0);
    check_eq("flush_store", bus.store_out, 0);
    check_eq("flush_occ", bus.occupancy, 0);
    check_eq("flush_rdy", bus.in_ready, 1);

    // 4b. flush with one entry while C is actually accepted
    send_alu(32'hD3);
    tick();
    send_alu(32'hC1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    check_eq("flush_acc_valid", bus.out_valid, 0);
    tick();
    check_eq("flush_c_gone_valid", bus.out_valid, 0);
    check_eq("flush_c_gone_occ", bus.occupancy, 0);

    // 5. store gating followed by a bubble
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h55, 32'h1000, 32'h84, 32'h80, 32'h00a12023);
    tick();
    check_eq("st_store", bus.store_out, 1);
    check_eq("st_insn", bus.instruction_out, 32'h00a12023);
    check_eq("st_opb", bus.opb_dataout, 32'h55);
    idle();
    tick();
    check_eq("st_bubble_store", bus.store_out, 0);
    check_eq("st_bubble_insn", bus.instruction_out, 32'h13);

    // 6. reset mid-stall with two entries
    bus.out_ready = 1'b0;
    send_alu(32'hE1);
    tick();
    send_alu(32'hE2);
    tick();
    check_eq("rst2_pre_occ", bus.occupancy, 2);
    rst = 1'b1;
    bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    idle();
    check_eq("rst2_occ", bus.occupancy, 0);
    check_eq("rst2_rdy", bus.in_ready, 1);
    check_eq("rst2_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'hCAFE0001, 32'h12345678, 32'h204, 32'h200, 32'h00412083);
    tick();
    idle();
    check_eq("f_valid", bus.out_valid, 1);
    check_eq("f_load", bus.load_out, 1);
    check_eq("f_store", bus.store_out, 0);
    check_eq("f_memreg", bus.mem_reg_out, 2);
    check_eq("f_opb", bus.opb_dataout, 32'hCAFE0001);
    check_eq("f_alu", bus.alu_res_out, 32'h12345678);
    check_eq("f_npc", bus.next_sel_address, 32'h204);
    check_eq("f_pc", bus.pre_address_out, 32'h200);
    check_eq("f_insn", bus.instruction_out, 32'h00412083);
    tick();
    check_eq("f_load_bubble", bus.load_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
